// File: rtl/frogger_pkg.sv
// Shared playfield geometry and the log rider state encoding.
package frogger_pkg;

  localparam logic [9:0] BLOCKSIZE      = 10'd32;
  localparam logic [9:0] X_OFFSET_LEFT  = 10'd96;
  localparam logic [9:0] X_OFFSET_RIGHT = 10'd544;
  localparam int         NUM_LANES      = 6;
  localparam int         LOGS_PER_LANE  = 3;

  typedef enum logic [1:0] {
    OFF_RIVER = 2'd0,
    RIDE      = 2'd1,
    SINK      = 2'd2,
    DEAD      = 2'd3
  } rider_state_t;

endpackage

// File: rtl/log_hit_finder.sv
// Combinational test of the frog centre against every log of one lane.
// The lowest-indexed log under the centre wins.
module log_hit_finder import frogger_pkg::*; #(
  parameter int N_LOGS = LOGS_PER_LANE
) (
  input  logic [N_LOGS-1:0][9:0] log_x_i,
  input  logic [9:0]             len_i,
  input  logic [10:0]            cx_i,
  output logic                   hit_o,
  output logic [1:0]             hit_idx_o,
  output logic [N_LOGS-1:0]      hit_vec_o
);

  // Span test at 11 bits so log_x + len never wraps.
  always_comb begin
    hit_vec_o = '0;
    for (int i = 0; i < N_LOGS; i++) begin
      hit_vec_o[i] = ({1'b0, log_x_i[i]} <= cx_i) &&
                     (cx_i < ({1'b0, log_x_i[i]} + {1'b0, len_i}));
    end
  end

  // Priority pick: scanning downward leaves the lowest hit index.
  always_comb begin
    hit_o     = 1'b0;
    hit_idx_o = '0;
    for (int i = N_LOGS - 1; i >= 0; i--) begin
      if (hit_vec_o[i]) begin
        hit_o     = 1'b1;
        hit_idx_o = 2'(i);
      end
    end
  end

endmodule

// File: rtl/log_rider.sv
// Tracks whether the frog stands on a log in its river lane, emits carry
// pulses that follow the log's 1-pixel steps, and times the sink/drown.
module log_rider #(
  parameter logic [9:0]  BLOCKSIZE      = frogger_pkg::BLOCKSIZE,
  parameter logic [9:0]  X_OFFSET_LEFT  = frogger_pkg::X_OFFSET_LEFT,
  parameter logic [9:0]  X_OFFSET_RIGHT = frogger_pkg::X_OFFSET_RIGHT,
  parameter int          NUM_LANES      = frogger_pkg::NUM_LANES,
  parameter int          LOGS_PER_LANE  = frogger_pkg::LOGS_PER_LANE,
  parameter logic [23:0] SINK_CYCLES    = 24'd5000000
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [NUM_LANES*LOGS_PER_LANE*10-1:0] log_x_flat,
  input  logic [NUM_LANES*10-1:0]               loglen_flat,
  input  logic [9:0]                            frog_x,
  input  logic [2:0]                            frog_row,
  input  logic                                  respawn,
  output logic                                  riding,
  output logic [1:0]                            ride_log,
  output logic                                  carry_left,
  output logic                                  carry_right,
  output logic                                  sinking,
  output logic                                  drowned
);
  import frogger_pkg::*;

  rider_state_t state_q, state_d;
  logic [23:0] cnt_q, cnt_d;
  logic [9:0]  prev_x_q, prev_x_d;
  logic [2:0]  prev_row_q;
  logic [1:0]  ride_log_q, ride_log_d;
  logic        riding_q, sinking_q, carry_l_q, carry_l_d, carry_r_q, carry_r_d;
  logic        drowned_q, drowned_d;

  logic [LOGS_PER_LANE-1:0][9:0] lanes_x [NUM_LANES];
  logic [9:0]                    lanes_len [NUM_LANES];
  logic [LOGS_PER_LANE-1:0][9:0] lane_x;
  logic [9:0]                    lane_len, cur_log_x, hit_log_x, delta;
  logic [LOGS_PER_LANE-1:0]      hit_vec;
  logic [1:0]                    hit_idx;
  logic [10:0]                   cx;
  logic [2:0]                    lane;
  logic                          hit, in_river, at_edge, on_latched;

  // Unpack the flat buses into per-lane views.
  always_comb begin
    for (int l = 0; l < NUM_LANES; l++) begin
      lanes_len[l] = loglen_flat[l*10 +: 10];
      for (int i = 0; i < LOGS_PER_LANE; i++) begin
        lanes_x[l][i] = log_x_flat[l*LOGS_PER_LANE*10 + i*10 +: 10];
      end
    end
  end

  assign in_river = (frog_row < 3'(NUM_LANES));
  assign lane     = in_river ? frog_row : 3'd0;
  assign lane_x   = lanes_x[lane];
  assign lane_len = lanes_len[lane];
  assign cx       = {1'b0, frog_x} + {2'b00, BLOCKSIZE[9:1]};
  assign at_edge  = ({1'b0, frog_x} < {1'b0, X_OFFSET_LEFT}) ||
                    (({1'b0, frog_x} + {1'b0, BLOCKSIZE}) > {1'b0, X_OFFSET_RIGHT});

  log_hit_finder #(.N_LOGS(LOGS_PER_LANE)) u_hit (
    .log_x_i   (lane_x),
    .len_i     (lane_len),
    .cx_i      (cx),
    .hit_o     (hit),
    .hit_idx_o (hit_idx),
    .hit_vec_o (hit_vec)
  );

  // Select the latched log and the newly hit log within the lane.
  always_comb begin
    cur_log_x  = lane_x[0];
    hit_log_x  = lane_x[0];
    on_latched = hit_vec[0];
    for (int i = 0; i < LOGS_PER_LANE; i++) begin
      if (ride_log_q == 2'(i)) begin
        cur_log_x  = lane_x[i];
        on_latched = hit_vec[i];
      end
      if (hit_idx == 2'(i)) hit_log_x = lane_x[i];
    end
  end

  assign delta = cur_log_x - prev_x_q;

  // Next-state, carry decision and sink timer; respawn overrides all.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    prev_x_d   = prev_x_q;
    ride_log_d = ride_log_q;
    carry_l_d  = 1'b0;
    carry_r_d  = 1'b0;
    drowned_d  = 1'b0;
    unique case (state_q)
      OFF_RIVER: begin
        if (in_river) begin
          if (hit) begin
            state_d    = RIDE;
            ride_log_d = hit_idx;
            prev_x_d   = hit_log_x;
          end else begin
            state_d = SINK;
          end
        end
      end
      RIDE: begin
        prev_x_d = cur_log_x;
        if (!in_river) begin
          state_d = OFF_RIVER;
        end else if (frog_row != prev_row_q) begin
          if (hit) begin
            ride_log_d = hit_idx;
            prev_x_d   = hit_log_x;
          end else begin
            state_d = SINK;
          end
        end else if (at_edge) begin
          state_d = SINK;
        end else if (delta != 10'd0 && delta != 10'd1 && delta != 10'h3FF) begin
          state_d = SINK;
        end else if (!on_latched) begin
          // Hopped onto a neighbour: retarget without carrying this cycle.
          if (hit) begin
            ride_log_d = hit_idx;
            prev_x_d   = hit_log_x;
          end else begin
            state_d = SINK;
          end
        end else begin
          carry_r_d = (delta == 10'd1);
          carry_l_d = (delta == 10'h3FF);
        end
      end
      SINK: begin
        if (cnt_q == SINK_CYCLES - 24'd1) begin
          drowned_d = 1'b1;
          cnt_d     = '0;
          state_d   = DEAD;
        end else begin
          cnt_d = cnt_q + 24'd1;
        end
      end
      DEAD: begin
      end
      default: state_d = OFF_RIVER;
    endcase
    if (respawn) begin
      state_d    = OFF_RIVER;
      cnt_d      = '0;
      ride_log_d = '0;
      carry_l_d  = 1'b0;
      carry_r_d  = 1'b0;
      drowned_d  = 1'b0;
    end
  end

  // State, tracking registers and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= OFF_RIVER;
      cnt_q      <= '0;
      prev_x_q   <= '0;
      prev_row_q <= 3'd7;
      ride_log_q <= '0;
      riding_q   <= 1'b0;
      sinking_q  <= 1'b0;
      carry_l_q  <= 1'b0;
      carry_r_q  <= 1'b0;
      drowned_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      prev_x_q   <= prev_x_d;
      prev_row_q <= frog_row;
      ride_log_q <= ride_log_d;
      riding_q   <= (state_d == RIDE);
      sinking_q  <= (state_d == SINK);
      carry_l_q  <= carry_l_d;
      carry_r_q  <= carry_r_d;
      drowned_q  <= drowned_d;
    end
  end

  assign riding      = riding_q;
  assign ride_log    = ride_log_q;
  assign carry_left  = carry_l_q;
  assign carry_right = carry_r_q;
  assign sinking     = sinking_q;
  assign drowned     = drowned_q;

endmodule

// File: tb/tb_log_rider.sv
// Scenario bench for log_rider with a short sink timer. Pulse outputs are
// checked by a scoreboard of expected (pulse, cycle) entries; levels inline.
module tb_log_rider;
  import frogger_pkg::*;

  localparam logic [2:0] P_CL = 3'b001;
  localparam logic [2:0] P_CR = 3'b010;
  localparam logic [2:0] P_DR = 3'b100;

  typedef struct {
    logic [2:0] code;
    int         cyc;
  } pulse_t;

  logic         clk, reset, respawn;
  logic [179:0] log_x_flat;
  logic [59:0]  loglen_flat;
  logic [9:0]   frog_x;
  logic [2:0]   frog_row;
  logic         riding, carry_left, carry_right, sinking, drowned;
  logic [1:0]   ride_log;

  int     total = 0;
  int     bad   = 0;
  int     cyc   = 0;
  pulse_t exp_q[$];

  log_rider #(.SINK_CYCLES(24'd8)) dut (
    .clk         (clk),
    .reset       (reset),
    .log_x_flat  (log_x_flat),
    .loglen_flat (loglen_flat),
    .frog_x      (frog_x),
    .frog_row    (frog_row),
    .respawn     (respawn),
    .riding      (riding),
    .ride_log    (ride_log),
    .carry_left  (carry_left),
    .carry_right (carry_right),
    .sinking     (sinking),
    .drowned     (drowned)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor: every observed pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!reset && (carry_left || carry_right || drowned)) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_pulse cyc=%0d got={dr,cr,cl}=%b want=none", cyc,
                 {drowned, carry_right, carry_left});
      end else begin
        pulse_t e;
        e = exp_q.pop_front();
        if ({drowned, carry_right, carry_left} !== e.code || cyc != e.cyc) begin
          bad++;
          $display("FAIL pulse got=%b@%0d want=%b@%0d", {drowned, carry_right, carry_left},
                   cyc, e.code, e.cyc);
        end
      end
    end
  end

  task automatic step(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_log(input int lane, input int idx, input int x);
    log_x_flat[lane*30 + idx*10 +: 10] = 10'(x);
  endtask

  task automatic set_len(input int lane, input int len);
    loglen_flat[lane*10 +: 10] = 10'(len);
  endtask

  task automatic do_respawn();
    frog_row = 3'd7;
    respawn  = 1'b1;
    step();
    respawn  = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(3);
    reset = 1'b0;
    step();
    total++;
    if ({riding, ride_log, carry_left, carry_right, sinking, drowned} !== 7'd0) begin
      bad++;
      $display("FAIL reset_outputs got=%b want=0", {riding, ride_log, carry_left,
               carry_right, sinking, drowned});
    end
    total++;
    if (dut.state_q !== OFF_RIVER) begin
      bad++;
      $display("FAIL reset_state got=%0d want=%0d", dut.state_q, OFF_RIVER);
    end
    step(3);
    total++;
    if ({riding, sinking} !== 2'b00 || dut.state_q !== OFF_RIVER) begin
      bad++;
      $display("FAIL row7_idle got riding=%b sinking=%b state=%0d want 0,0,0", riding,
               sinking, dut.state_q);
    end
  endtask

  task automatic test_ride_carry();
    set_len(1, 96);
    set_log(1, 0, 200);
    set_log(1, 1, 350);
    set_log(1, 2, 600);
    frog_x   = 10'd220;
    frog_row = 3'd1;
    step();
    total++;
    if (riding !== 1'b1 || ride_log !== 2'd0) begin
      bad++;
      $display("FAIL ride_entry got riding=%b log=%0d want 1,0", riding, ride_log);
    end
    step(2);
    set_log(1, 0, 201);
    exp_q.push_back('{P_CR, cyc + 1});
    step();
    total++;
    if (carry_right !== 1'b1 || carry_left !== 1'b0) begin
      bad++;
      $display("FAIL carry_right got r=%b l=%b want 1,0", carry_right, carry_left);
    end
    step(3);
    set_log(1, 0, 200);
    exp_q.push_back('{P_CL, cyc + 1});
    step();
    total++;
    if (carry_left !== 1'b1 || carry_right !== 1'b0) begin
      bad++;
      $display("FAIL carry_left got l=%b r=%b want 1,0", carry_left, carry_right);
    end
    step(2);
  endtask

  task automatic test_hop_abort();
    // Log0 steps in the same cycle the frog lands on log1: no carry.
    set_log(1, 0, 201);
    frog_x = 10'd360;
    step();
    total++;
    if (riding !== 1'b1 || ride_log !== 2'd1) begin
      bad++;
      $display("FAIL hop got riding=%b log=%0d want 1,1", riding, ride_log);
    end
    step(2);
    set_log(1, 1, 351);
    exp_q.push_back('{P_CR, cyc + 1});
    step(3);
    frog_x = 10'd300;
    step();
    total++;
    if (sinking !== 1'b1 || riding !== 1'b0) begin
      bad++;
      $display("FAIL hop_water got sinking=%b riding=%b want 1,0", sinking, riding);
    end
    step(3);
    do_respawn();
    total++;
    if ({riding, ride_log, sinking} !== 4'd0 || dut.state_q !== OFF_RIVER) begin
      bad++;
      $display("FAIL abort got r=%b log=%0d s=%b state=%0d want 0,0,0,0", riding, ride_log,
               sinking, dut.state_q);
    end
    step(12);
  endtask

  task automatic test_water();
    set_len(0, 96);
    set_log(0, 0, 300);
    set_log(0, 1, 400);
    set_log(0, 2, 500);
    frog_x   = 10'd100;
    frog_row = 3'd0;
    exp_q.push_back('{P_DR, cyc + 1 + 8});
    step();
    total++;
    if (sinking !== 1'b1 || riding !== 1'b0) begin
      bad++;
      $display("FAIL water_sink got sinking=%b riding=%b want 1,0", sinking, riding);
    end
    for (int k = 0; k < 7; k++) begin
      step();
      total++;
      if (sinking !== 1'b1 || drowned !== 1'b0) begin
        bad++;
        $display("FAIL sink_hold k=%0d got s=%b d=%b want 1,0", k, sinking, drowned);
      end
    end
    step();
    total++;
    if (drowned !== 1'b1 || sinking !== 1'b0 || dut.state_q !== DEAD) begin
      bad++;
      $display("FAIL drown got d=%b s=%b state=%0d want 1,0,%0d", drowned, sinking,
               dut.state_q, DEAD);
    end
    step(2);
    total++;
    if (dut.state_q !== DEAD || drowned !== 1'b0) begin
      bad++;
      $display("FAIL dead_hold got state=%0d d=%b want %0d,0", dut.state_q, drowned, DEAD);
    end
    do_respawn();
    total++;
    if ({riding, ride_log, carry_left, carry_right, sinking, drowned} !== 7'd0 ||
        dut.state_q !== OFF_RIVER) begin
      bad++;
      $display("FAIL respawn got outs=%b state=%0d want 0,0", {riding, ride_log, carry_left,
               carry_right, sinking, drowned}, dut.state_q);
    end
  endtask

  task automatic test_wrap();
    set_len(0, 128);
    set_log(0, 0, 300);
    set_log(0, 1, 400);
    set_log(0, 2, 32);
    frog_x   = 10'd100;
    frog_row = 3'd0;
    step(2);
    total++;
    if (riding !== 1'b1 || ride_log !== 2'd2) begin
      bad++;
      $display("FAIL wrap_entry got riding=%b log=%0d want 1,2", riding, ride_log);
    end
    set_log(0, 2, 640);
    step();
    total++;
    if (sinking !== 1'b1 || riding !== 1'b0) begin
      bad++;
      $display("FAIL wrap got sinking=%b riding=%b want 1,0", sinking, riding);
    end
    do_respawn();
  endtask

  task automatic test_edge();
    set_len(2, 96);
    set_log(2, 0, 64);
    set_log(2, 1, 480);
    set_log(2, 2, 700);
    frog_x   = 10'd96;
    frog_row = 3'd2;
    step(2);
    total++;
    if (riding !== 1'b1 || sinking !== 1'b0) begin
      bad++;
      $display("FAIL edge_left_ok got riding=%b sinking=%b want 1,0", riding, sinking);
    end
    frog_x = 10'd95;
    step();
    total++;
    if (sinking !== 1'b1) begin
      bad++;
      $display("FAIL edge_left got sinking=%b want 1", sinking);
    end
    do_respawn();
    frog_x   = 10'd512;
    frog_row = 3'd2;
    step(2);
    total++;
    if (riding !== 1'b1 || ride_log !== 2'd1 || sinking !== 1'b0) begin
      bad++;
      $display("FAIL edge_right_ok got r=%b log=%0d s=%b want 1,1,0", riding, ride_log,
               sinking);
    end
    frog_x = 10'd513;
    step();
    total++;
    if (sinking !== 1'b1) begin
      bad++;
      $display("FAIL edge_right got sinking=%b want 1", sinking);
    end
    do_respawn();
  endtask

  initial begin
    reset       = 1'b1;
    respawn     = 1'b0;
    frog_x      = 10'd0;
    frog_row    = 3'd7;
    log_x_flat  = {18{10'd700}};
    loglen_flat = {6{10'd96}};
    test_reset();
    test_ride_carry();
    test_hop_abort();
    test_water();
    test_wrap();
    test_edge();
    step(4);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL missing_pulses got pending=%0d want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
